// File: rtl/ifu_fetch_buffer_pkg.sv
// ifu_fetch_buffer_pkg
//   Shared definitions for the instruction-fetch buffer slice: line/instruction
//   geometry, the default reset PC, the fetch state type and a line-address
//   helper. Imported by ifu_line_buf and ifu_fetch_buffer.
package ifu_fetch_buffer_pkg;

    localparam int unsigned LINE_W   = 128;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned TAG_W    = 32 - OFFSET_W;
    localparam int unsigned SEL_W    = OFFSET_W - 2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        REQ   = 1'b1
    } state_t;

    // Line-aligned address containing byte address a.
    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~32'((LINE_W / 8) - 1);
    endfunction

endpackage

// File: rtl/ifu_line_buf.sv
// ifu_line_buf
//   Single-line instruction buffer: holds one cache line with its tag and a
//   valid bit, reports a hit for the looked-up tag and selects one 32-bit word.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     fill_en      write fill_data/fill_tag and mark the line valid
//     fill_data    128-bit line from the cache
//     fill_tag     pc[31:4] of the filled line
//     inval        clear the valid bit; wins over fill_en in the same cycle
//     lookup_tag   pc[31:4] being fetched
//     word_sel     pc[3:2] being fetched
//     hit          line valid and tag matches lookup_tag
//     word         selected instruction word (word 0 = bits [31:0])
module ifu_line_buf
    import ifu_fetch_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_en,
    input  logic [LINE_W-1:0] fill_data,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic              inval,
    input  logic [TAG_W-1:0]  lookup_tag,
    input  logic [SEL_W-1:0]  word_sel,
    output logic              hit,
    output logic [INST_W-1:0] word
);

    logic [LINE_W-1:0] line_data;
    logic [TAG_W-1:0]  line_tag;
    logic              line_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_data  <= '0;
            line_tag   <= '0;
            line_valid <= 1'b0;
        end else if (inval) begin
            line_valid <= 1'b0;
        end else if (fill_en) begin
            line_data  <= fill_data;
            line_tag   <= fill_tag;
            line_valid <= 1'b1;
        end
    end

    assign hit  = line_valid && (line_tag == lookup_tag);
    assign word = line_data[32'(word_sel) * INST_W +: INST_W];

endmodule

// File: rtl/ifu_fetch_buffer.sv
// ifu_fetch_buffer
//   Instruction-fetch stage between PC/redirect logic and the instruction cache.
//   Buffers the last returned 128-bit line and serves sequential 32-bit
//   instructions from it at one per cycle; requests a new line only when the
//   PC leaves the buffered line. Cache handshake: icache_req_valid is held with
//   a stable address until the single-cycle icache_ready pulse, and drops
//   combinationally in that pulse cycle.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     redirect_valid/pc  one-cycle redirect; pc[1:0] forced to 0
//     flush_line         invalidate the buffered line (fence.i)
//     icache_req_addr    registered line address of the outstanding request
//     icache_req_valid   line request to the cache
//     icache_rdata       line data, valid while icache_ready=1
//     icache_ready       one-cycle fill completion pulse
//     inst_valid/ready   handshake to decode
//     inst, inst_pc      instruction word and its PC
//   Optional build macro IFU_PERF_EN adds:
//     fetch_cnt          64-bit count of accepted instructions
//     fill_cnt           64-bit count of line requests launched
module ifu_fetch_buffer
    import ifu_fetch_buffer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          flush_line,
    output logic [31:0]   icache_req_addr,
    output logic          icache_req_valid,
    input  logic [127:0]  icache_rdata,
    input  logic          icache_ready,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]   fetch_cnt,
    output logic [63:0]   fill_cnt
`endif
);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic        fill_kill;
    logic        line_hit;
    logic        accept;
    logic        miss_launch;
    logic        fill_en;

    assign inst_pc          = pc;
    assign icache_req_addr  = req_addr;
    assign inst_valid       = (state == FETCH) && line_hit && !redirect_valid;
    assign accept           = inst_valid && inst_ready;
    assign miss_launch      = (state == FETCH) && !line_hit && !redirect_valid;
    assign icache_req_valid = (state == REQ) && !icache_ready;
    // A fill flushed earlier in this request (fill_kill) or in the pulse cycle
    // itself (inval priority inside the buffer) never reaches the line.
    assign fill_en          = (state == REQ) && icache_ready && !fill_kill;

    ifu_line_buf u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .fill_en    (fill_en),
        .fill_data  (icache_rdata),
        .fill_tag   (req_addr[31:OFFSET_W]),
        .inval      (flush_line),
        .lookup_tag (pc[31:OFFSET_W]),
        .word_sel   (pc[OFFSET_W-1:2]),
        .hit        (line_hit),
        .word       (inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            state     <= FETCH;
            req_addr  <= '0;
            fill_kill <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc & ~32'h3;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end

            if (state == FETCH) begin
                if (miss_launch) begin
                    req_addr <= line_base(pc);
                    state    <= REQ;
                end
            end else begin
                // Completion always clears the kill flag, even if a flush
                // arrives in the same cycle: that flush already blocks the
                // write and the next request must not inherit it.
                if (icache_ready) begin
                    fill_kill <= 1'b0;
                    state     <= FETCH;
                end else if (flush_line) begin
                    fill_kill <= 1'b1;
                end
            end
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            fill_cnt  <= '0;
        end else begin
            if (accept) begin
                fetch_cnt <= fetch_cnt + 64'd1;
            end
            if (miss_launch) begin
                fill_cnt <= fill_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// tb_ifu_fetch_buffer
//   Scoreboard bench for ifu_fetch_buffer. A cache responder with random
//   latency serves lines from a fixed memory image. The expected program order
//   of accepted PCs lives in a queue; a negedge monitor compares every
//   presented instruction and every line request against it. Directed
//   scenarios are followed by a randomized phase. Honours IFU_PERF_EN.
module tb_ifu_fetch_buffer;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic         clk;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         flush_line;
    logic [31:0]  icache_req_addr;
    logic         icache_req_valid;
    logic [127:0] icache_rdata;
    logic         icache_ready;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
`ifdef IFU_PERF_EN
    logic [63:0]  fetch_cnt;
    logic [63:0]  fill_cnt;
`endif

    ifu_fetch_buffer #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush_line       (flush_line),
        .icache_req_addr  (icache_req_addr),
        .icache_req_valid (icache_req_valid),
        .icache_rdata     (icache_rdata),
        .icache_ready     (icache_ready),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
`ifdef IFU_PERF_EN
        .fetch_cnt        (fetch_cnt),
        .fill_cnt         (fill_cnt),
`endif
        .inst_pc          (inst_pc)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] exp_q[$];      // expected pc of the next accepted instruction
    logic [31:0] acc_log[$];
    logic [31:0] acc_inst[$];
    int          acc_cyc[$];
    logic [31:0] fill_log[$];
    int          acc_cnt   = 0;
    int          ready_cnt = 0;
    logic        cache_hold = 1'b0;
    logic        out_req    = 1'b0;
    logic [31:0] held_addr  = '0;
    logic [31:0] prev_pc    = RST_PC;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        logic [1:0]  idx;
        idx = a[3:2];
        if (a[31:4] == 28'h800_0000) return 32'h1111_1111 * (32'(idx) + 32'd1);
        w = (a & ~32'h3) * 32'h9E37_79B1;
        return w ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'hF;
        return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cache model: one outstanding request, random latency, optional hold.
    initial begin
        bit busy;
        int cnt;
        bit fire;
        busy = 0;
        cnt  = 0;
        icache_ready = 1'b0;
        icache_rdata = '0;
        forever begin
            @(posedge clk); #1;
            fire = 0;
            if (rst) begin
                busy = 0;
            end else if (busy) begin
                if (!cache_hold) begin
                    if (cnt == 0) begin
                        fire = 1;
                        busy = 0;
                    end else begin
                        cnt--;
                    end
                end
            end else if (icache_req_valid) begin
                busy = 1;
                cnt  = $urandom_range(0, 3);
            end
            if (fire) icache_rdata = mem_line(icache_req_addr);
            icache_ready = fire;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            out_req = 1'b0;
            prev_pc = RST_PC;
        end else begin
            if (icache_ready) ready_cnt++;
            if (out_req) begin
                if (icache_ready) begin
                    chk("req_drop_on_ready", icache_req_valid, 1'b0);
                    out_req = 1'b0;
                end else begin
                    chk("req_held_valid", icache_req_valid, 1'b1);
                    chk("req_held_addr", icache_req_addr, held_addr);
                end
            end else if (icache_req_valid) begin
                chk("req_addr", icache_req_addr, prev_pc & 32'hFFFF_FFF0);
                held_addr = icache_req_addr;
                out_req   = 1'b1;
                fill_log.push_back(icache_req_addr);
            end

            if (redirect_valid) begin
                chk("valid_in_redirect", inst_valid, 1'b0);
            end else if (inst_valid && exp_q.size() > 0) begin
                chk("inst_pc", inst_pc, exp_q[0]);
                chk("inst", inst, mem_word(exp_q[0]));
                if (inst_ready) begin
                    acc_log.push_back(inst_pc);
                    acc_inst.push_back(inst);
                    acc_cyc.push_back(cyc);
                    acc_cnt++;
                    exp_q.push_back(exp_q.pop_front() + 32'd4);
                end
            end
            if (exp_q.size() > 0) prev_pc = exp_q[0];
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        flush_line = 1'b0;
        inst_ready = 1'b0;
        cache_hold = 1'b0;
        step();
        step();
        chk("rst_req_valid", icache_req_valid, 1'b0);
        chk("rst_req_addr", icache_req_addr, 32'h0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, RST_PC);
`ifdef IFU_PERF_EN
        chk("rst_fetch_cnt", fetch_cnt, 64'h0);
        chk("rst_fill_cnt", fill_cnt, 64'h0);
`endif
        exp_q.delete();
        exp_q.push_back(RST_PC);
        acc_log.delete();
        acc_inst.delete();
        acc_cyc.delete();
        fill_log.delete();
        acc_cnt = 0;
        ready_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        exp_q.delete();
        exp_q.push_back(a & ~32'h3);
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_acc(input int n, input string nm);
        int k;
        k = 0;
        while (acc_cnt < n && k < 300) begin step(); k++; end
        chk(nm, 64'(acc_cnt >= n), 64'd1);
    endtask

    task automatic wait_fill(input int n, input string nm);
        int k;
        k = 0;
        while (fill_log.size() < n && k < 300) begin step(); k++; end
        chk(nm, 64'(fill_log.size() >= n), 64'd1);
    endtask

    task automatic perf_chk(input string nm);
`ifdef IFU_PERF_EN
        chk({nm, "_fetch_cnt"}, fetch_cnt, 64'(acc_cnt));
        chk({nm, "_fill_cnt"}, fill_cnt, 64'(fill_log.size()));
`else
        chk({nm, "_acc_count"}, 64'(acc_log.size()), 64'(acc_cnt));
`endif
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        flush_line = 1'b0;
        inst_ready = 1'b0;

        // Sequential line delivery from reset.
        do_reset();
        inst_ready = 1'b1;
        wait_acc(4, "t1_four_accepts");
        chk("t1_fills_at_4", 64'(fill_log.size()), 64'd1);
        if (acc_log.size() >= 4) begin
            chk("t1_consecutive", 64'(acc_cyc[3] - acc_cyc[0]), 64'd3);
            for (int unsigned i = 0; i < 4; i++) begin
                chk("t1_pc", acc_log[i], RST_PC + 32'(4 * i));
                chk("t1_inst", acc_inst[i], 32'h1111_1111 * 32'(i + 1));
            end
        end
        wait_fill(2, "t1_second_fill");
        if (fill_log.size() >= 2) begin
            chk("t1_fill0", fill_log[0], 32'h8000_0000);
            chk("t1_fill1", fill_log[1], 32'h8000_0010);
        end
        perf_chk("t1");

        // Decode stall on 0x80000004.
        do_reset();
        inst_ready = 1'b1;
        wait_acc(1, "t2_first_accept");
        inst_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            chk("t2_stall_valid", inst_valid, 1'b1);
            chk("t2_stall_pc", inst_pc, 32'h8000_0004);
            chk("t2_stall_inst", inst, 32'h2222_2222);
            chk("t2_no_request", 64'(fill_log.size()), 64'd1);
        end
        chk("t2_acc_stalled", 64'(acc_cnt), 64'd1);
        inst_ready = 1'b1;
        wait_acc(2, "t2_resume");
        if (acc_log.size() >= 2) chk("t2_resume_pc", acc_log[1], 32'h8000_0004);

        // Redirect while the 0x80000010 fill is outstanding.
        do_reset();
        inst_ready = 1'b1;
        wait_acc(4, "t3_four_accepts");
        cache_hold = 1'b1;
        wait_fill(2, "t3_req_10");
        do_redirect(32'h8000_0108);
        cache_hold = 1'b0;
        wait_fill(3, "t3_req_100");
        chk("t3_line_tag", dut.u_line_buf.line_tag, 28'h800_0001);
        if (fill_log.size() >= 3) chk("t3_fill2", fill_log[2], 32'h8000_0100);
        wait_acc(5, "t3_after_redirect");
        if (acc_log.size() >= 5) chk("t3_first_pc", acc_log[4], 32'h8000_0108);

        // Redirect inside the buffered line.
        do_reset();
        begin
            int k;
            k = 0;
            while (!inst_valid && k < 100) begin step(); k++; end
            chk("t4_line_ready", inst_valid, 1'b1);
        end
        do_redirect(32'h8000_000B);
        inst_ready = 1'b1;
        wait_acc(1, "t4_accept");
        if (acc_log.size() >= 1) begin
            chk("t4_pc", acc_log[0], 32'h8000_0008);
            chk("t4_inst", acc_inst[0], 32'h3333_3333);
        end
        chk("t4_no_request", 64'(fill_log.size()), 64'd1);

        // Flush while a fill is outstanding.
        do_reset();
        inst_ready = 1'b1;
        cache_hold = 1'b1;
        wait_fill(1, "t5_req");
        flush_line = 1'b1;
        step();
        flush_line = 1'b0;
        cache_hold = 1'b0;
        wait_acc(1, "t5_accept");
        chk("t5_fill_count", 64'(fill_log.size()), 64'd2);
        if (fill_log.size() >= 2) chk("t5_refetch_addr", fill_log[1], 32'h8000_0000);
        chk("t5_ready_count", 64'(ready_cnt), 64'd2);
        if (acc_log.size() >= 1) chk("t5_pc", acc_log[0], 32'h8000_0000);

        // PC wrap at 2^32.
        do_reset();
        inst_ready = 1'b1;
        do_redirect(32'hFFFF_FFFC);
        wait_acc(2, "t6_accepts");
        if (acc_log.size() >= 2) begin
            chk("t6_pc0", acc_log[0], 32'hFFFF_FFFC);
            chk("t6_pc1", acc_log[1], 32'h0000_0000);
        end
        if (fill_log.size() >= 2) begin
            chk("t6_fill0", fill_log[0], 32'hFFFF_FFF0);
            chk("t6_fill1", fill_log[1], 32'h0000_0000);
        end
        perf_chk("t6");

        // Randomized traffic.
        do_reset();
        for (int unsigned i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            inst_ready = ($urandom_range(0, 3) != 0);
            flush_line = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    tgt = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
                else
                    tgt = 32'h8000_0000 + 32'($urandom_range(0, 1023));
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                exp_q.delete();
                exp_q.push_back(tgt & ~32'h3);
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        flush_line = 1'b0;
        inst_ready = 1'b0;
        step();
        chk("rnd_progress", 64'(acc_cnt > 200), 64'd1);
        perf_chk("rnd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
